nes_ram_access_arbiter: RTL and testbench

- Shares one single-port external RAM (24-bit byte address, 8-bit data) between three requesters: 0 = PPU fetch, 1 = 6502 CPU bus, 2 = NIOS loader/debug.
- Round-robin arbitration with at most one access in flight. Sequences RAM enable, write-enable and read-latency capture.
- Exports the last granted address and owner for the NIOS PIO status inputs.

---
 rtl/nes_ram_access_arbiter_if.sv | 42 ++++
 rtl/nes_ram_access_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_nes_ram_access_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nes_ram_access_arbiter_if.sv
// Bus bundle for nes_ram_access_arbiter.
// Carries the three requester channels, the single-port RAM channel and the
// status outputs used by the NIOS PIO inputs.
//   slave  : the arbiter side (takes requests and RAM read data; drives
//            grants, completions, RAM controls and status)
//   master : requesters and the RAM model (the opposite directions)
interface nes_ram_access_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic [2:0]        req;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        gnt;
  logic [2:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic [1:0]        cur_owner;
  logic [ADDR_W-1:0] cur_addr;

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_rdata,
    output gnt, done, rdata, ram_en, ram_we, ram_addr, ram_wdata,
           busy, cur_owner, cur_addr
  );

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_rdata,
    input  gnt, done, rdata, ram_en, ram_we, ram_addr, ram_wdata,
           busy, cur_owner, cur_addr
  );
endinterface

// File: rtl/nes_ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between three requesters
// (0 = PPU fetch, 1 = 6502 CPU bus, 2 = NIOS loader/debug), one access in
// flight at a time. All outputs are registered.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : nes_ram_access_arbiter_if.slave -- req/we/addrN/wdataN in,
//           gnt/done pulses, rdata, RAM en/we/addr/wdata out, ram_rdata in,
//           busy/cur_owner/cur_addr status out
// RD_LAT: RAM read latency in cycles, legal range 1..7.
module nes_ram_access_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  nes_ram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'd3;

  state_t            r_state;
  logic [1:0]        r_last_gnt;
  logic [2:0]        r_cnt;
  logic [2:0]        r_gnt;
  logic [2:0]        r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_busy;
  logic [1:0]        r_cur_owner;
  logic [ADDR_W-1:0] r_cur_addr;

  state_t            w_state_nxt;
  logic [1:0]        w_last_gnt_nxt;
  logic [2:0]        w_cnt_nxt;
  logic [2:0]        w_gnt_nxt;
  logic [2:0]        w_done_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_ram_en_nxt;
  logic              w_ram_we_nxt;
  logic [ADDR_W-1:0] w_ram_addr_nxt;
  logic [DATA_W-1:0] w_ram_wdata_nxt;
  logic              w_busy_nxt;
  logic [1:0]        w_cur_owner_nxt;
  logic [ADDR_W-1:0] w_cur_addr_nxt;

  logic              w_pick_vld;
  logic [1:0]        w_pick;
  logic [1:0]        w_cand;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [2:0]        w_owner_oh;

  // Scan last_gnt+1, +2, +3 (mod 3); the first requesting index wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = 2'd0;
    w_cand     = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      w_cand = 2'((32'(r_last_gnt) + k) % 3);
      if (!w_pick_vld && bus.req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_addr  = bus.addr2;
    w_sel_wdata = bus.wdata2;
    case (w_pick)
      2'd0:    begin w_sel_addr = bus.addr0; w_sel_wdata = bus.wdata0; end
      2'd1:    begin w_sel_addr = bus.addr1; w_sel_wdata = bus.wdata1; end
      default: begin w_sel_addr = bus.addr2; w_sel_wdata = bus.wdata2; end
    endcase
  end

  // cur_owner doubles as the in-flight requester index (never 3 while busy).
  assign w_owner_oh = 3'b001 << r_cur_owner;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_gnt_nxt  = r_last_gnt;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = '0;
    w_done_nxt      = '0;
    w_rdata_nxt     = r_rdata;
    w_ram_en_nxt    = 1'b0;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_busy_nxt      = r_busy;
    w_cur_owner_nxt = r_cur_owner;
    w_cur_addr_nxt  = r_cur_addr;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt       = 3'b001 << w_pick;
          w_ram_en_nxt    = 1'b1;
          w_ram_we_nxt    = bus.we[w_pick];
          w_ram_addr_nxt  = w_sel_addr;
          w_ram_wdata_nxt = w_sel_wdata;
          w_cur_addr_nxt  = w_sel_addr;
          w_cur_owner_nxt = w_pick;
          w_last_gnt_nxt  = w_pick;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // r_ram_we is still the granted access type during this cycle.
        if (r_ram_we) begin
          w_done_nxt      = w_owner_oh;
          w_cur_owner_nxt = OWNER_NONE;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt   = 3'(RD_LAT - 1);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_rdata_nxt     = bus.ram_rdata;
          w_done_nxt      = w_owner_oh;
          w_cur_owner_nxt = OWNER_NONE;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= 2'd2;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
      r_cur_owner <= OWNER_NONE;
      r_cur_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_rdata     <= w_rdata_nxt;
      r_ram_en    <= w_ram_en_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_cur_owner <= w_cur_owner_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.busy      = r_busy;
  assign bus.cur_owner = r_cur_owner;
  assign bus.cur_addr  = r_cur_addr;

endmodule

// File: tb/tb_nes_ram_access_arbiter.sv
// Bench for nes_ram_access_arbiter: three instances (RD_LAT 2, 1, 7) with a
// latency-accurate RAM model each. Done pulses are checked by a per-instance
// monitor against a queue of expected completions.
module tb_nes_ram_access_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef struct {
    logic [2:0] done;
    bit         rd;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb [3][$];

  nes_ram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus [3] ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_model(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
      logic [7:0] pipe [8];
      exp_t       e;

      nes_ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(L)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus[g])
      );

      always @(posedge clk) begin
        pipe[0] <= (bus[g].ram_en && !bus[g].ram_we) ? ram_model(bus[g].ram_addr) : 8'h00;
        for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
      end
      assign bus[g].ram_rdata = pipe[L-1];

      always @(negedge clk) begin
        if (!reset) begin
          if (bus[g].gnt != 3'b000) chk($sformatf("dut%0d gnt_onehot", g), 32'($onehot(bus[g].gnt)), 1);
          if (bus[g].ram_we) chk($sformatf("dut%0d we_with_en", g), 32'(bus[g].ram_en), 1);
          if (bus[g].done != 3'b000) begin
            if (sb[g].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL dut%0d unexpected_done: got done=%b, expected none (cycle %0d)", g, bus[g].done, cyc);
            end else begin
              e = sb[g].pop_front();
              chk($sformatf("dut%0d done_vec", g), 32'(bus[g].done), 32'(e.done));
              chk($sformatf("dut%0d done_cycle", g), cyc, e.cyc);
              if (e.rd) chk($sformatf("dut%0d rdata", g), 32'(bus[g].rdata), 32'(e.rdata));
            end
          end
        end
      end
    end
  endgenerate

  task automatic chk_reset0();
    chk("rst gnt", 32'(bus[0].gnt), 0);
    chk("rst done", 32'(bus[0].done), 0);
    chk("rst rdata", 32'(bus[0].rdata), 0);
    chk("rst ram_en", 32'(bus[0].ram_en), 0);
    chk("rst ram_we", 32'(bus[0].ram_we), 0);
    chk("rst ram_addr", 32'(bus[0].ram_addr), 0);
    chk("rst ram_wdata", 32'(bus[0].ram_wdata), 0);
    chk("rst busy", 32'(bus[0].busy), 0);
    chk("rst cur_owner", 32'(bus[0].cur_owner), 3);
    chk("rst cur_addr", 32'(bus[0].cur_addr), 0);
  endtask

  int         c0;
  logic [7:0] fair_rd [3];
  logic [2:0] exp_g;

  initial begin
    reset = 1'b1;
    bus[0].req = '0; bus[0].we = '0; bus[0].addr0 = '0; bus[0].addr1 = '0; bus[0].addr2 = '0;
    bus[0].wdata0 = '0; bus[0].wdata1 = '0; bus[0].wdata2 = '0;
    bus[1].req = '0; bus[1].we = '0; bus[1].addr0 = '0; bus[1].addr1 = '0; bus[1].addr2 = '0;
    bus[1].wdata0 = '0; bus[1].wdata1 = '0; bus[1].wdata2 = '0;
    bus[2].req = '0; bus[2].we = '0; bus[2].addr0 = '0; bus[2].addr1 = '0; bus[2].addr2 = '0;
    bus[2].wdata0 = '0; bus[2].wdata1 = '0; bus[2].wdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset0();
    reset = 1'b0;
    tick();

    // Single write from requester 1.
    c0 = cyc;
    bus[0].req = 3'b010; bus[0].we = 3'b010; bus[0].addr1 = 24'h00ABCD; bus[0].wdata1 = 8'h5A;
    sb[0].push_back('{3'b010, 1'b0, 8'h00, c0 + 2});
    tick();
    chk("wr gnt", 32'(bus[0].gnt), 32'b010);
    chk("wr ram_en", 32'(bus[0].ram_en), 1);
    chk("wr ram_we", 32'(bus[0].ram_we), 1);
    chk("wr ram_addr", 32'(bus[0].ram_addr), 32'h00ABCD);
    chk("wr ram_wdata", 32'(bus[0].ram_wdata), 32'h5A);
    chk("wr busy", 32'(bus[0].busy), 1);
    chk("wr cur_owner", 32'(bus[0].cur_owner), 1);
    bus[0].req = '0; bus[0].we = '0;
    tick();
    chk("wr cur_addr", 32'(bus[0].cur_addr), 32'h00ABCD);
    chk("wr owner_none", 32'(bus[0].cur_owner), 3);
    chk("wr busy_low", 32'(bus[0].busy), 0);
    chk("wr ram_en_low", 32'(bus[0].ram_en), 0);

    // Single read from requester 0 at the top address.
    c0 = cyc;
    bus[0].req = 3'b001; bus[0].addr0 = 24'hFFFFFF;
    sb[0].push_back('{3'b001, 1'b1, 8'hC3, c0 + 4});
    tick();
    chk("rd gnt", 32'(bus[0].gnt), 32'b001);
    chk("rd ram_en", 32'(bus[0].ram_en), 1);
    chk("rd ram_we", 32'(bus[0].ram_we), 0);
    chk("rd ram_addr", 32'(bus[0].ram_addr), 32'hFFFFFF);
    chk("rd busy c1", 32'(bus[0].busy), 1);
    bus[0].req = '0;
    tick();
    chk("rd busy c2", 32'(bus[0].busy), 1);
    chk("rd ram_en c2", 32'(bus[0].ram_en), 0);
    tick();
    chk("rd busy c3", 32'(bus[0].busy), 1);
    tick();
    chk("rd busy c4", 32'(bus[0].busy), 0);
    chk("rd cur_addr", 32'(bus[0].cur_addr), 32'hFFFFFF);
    tick();
    chk("rd rdata_held", 32'(bus[0].rdata), 32'hC3);

    // Requester 2 arrives during requester 0's WAIT.
    c0 = cyc;
    bus[0].req = 3'b001; bus[0].addr0 = 24'h000100;
    sb[0].push_back('{3'b001, 1'b1, 8'h3D, c0 + 4});
    sb[0].push_back('{3'b100, 1'b0, 8'h00, c0 + 6});
    tick();
    chk("late gnt0", 32'(bus[0].gnt), 32'b001);
    bus[0].req = '0;
    tick();
    bus[0].req = 3'b100; bus[0].we = 3'b100; bus[0].addr2 = 24'h00FFFF; bus[0].wdata2 = 8'h77;
    chk("late gnt c2", 32'(bus[0].gnt), 0);
    tick();
    chk("late gnt c3", 32'(bus[0].gnt), 0);
    tick();
    chk("late gnt done_cycle", 32'(bus[0].gnt), 0);
    tick();
    chk("late gnt2", 32'(bus[0].gnt), 32'b100);
    chk("late ram_addr", 32'(bus[0].ram_addr), 32'h00FFFF);
    chk("late ram_wdata", 32'(bus[0].ram_wdata), 32'h77);
    chk("late ram_we", 32'(bus[0].ram_we), 1);
    bus[0].req = '0; bus[0].we = '0;
    repeat (2) tick();

    // Reset while a read is in WAIT: abandoned, no done.
    c0 = cyc;
    bus[0].req = 3'b010; bus[0].addr1 = 24'h000042;
    tick();
    chk("rstw gnt1", 32'(bus[0].gnt), 32'b010);
    bus[0].req = '0;
    tick();
    reset = 1'b1;
    #1;
    chk_reset0();
    tick();
    reset = 1'b0;

    // All three reading continuously: 0,1,2,0,1,2 four cycles apart.
    c0 = cyc;
    fair_rd[0] = 8'h99; fair_rd[1] = 8'h2D; fair_rd[2] = 8'h4C;
    bus[0].req = 3'b111; bus[0].we = 3'b000;
    bus[0].addr0 = 24'h0000A5; bus[0].addr1 = 24'h000011; bus[0].addr2 = 24'h123456;
    for (int k = 0; k < 6; k++)
      sb[0].push_back('{3'b001 << (k % 3), 1'b1, fair_rd[k % 3], c0 + 4 + 4 * k});
    for (int n = 1; n <= 24; n++) begin
      tick();
      exp_g = ((n - 1) % 4 == 0) ? (3'b001 << (((n - 1) / 4) % 3)) : 3'b000;
      chk($sformatf("fair gnt n=%0d", n), 32'(bus[0].gnt), 32'(exp_g));
      if (exp_g != 3'b000) chk($sformatf("fair owner n=%0d", n), 32'(bus[0].cur_owner), ((n - 1) / 4) % 3);
      if (n == 21) bus[0].req = '0;
    end
    repeat (2) tick();

    // Latency regression: RD_LAT=1 (dut1) and RD_LAT=7 (dut2).
    c0 = cyc;
    bus[1].req = 3'b100; bus[1].addr2 = 24'h000080;
    bus[2].req = 3'b010; bus[2].addr1 = 24'hABCDEF;
    sb[1].push_back('{3'b100, 1'b1, 8'hBC, c0 + 3});
    sb[2].push_back('{3'b010, 1'b1, 8'hB5, c0 + 9});
    tick();
    chk("lat1 gnt", 32'(bus[1].gnt), 32'b100);
    chk("lat7 gnt", 32'(bus[2].gnt), 32'b010);
    bus[1].req = '0; bus[2].req = '0;
    repeat (10) tick();
    chk("lat1 rdata_held", 32'(bus[1].rdata), 32'hBC);
    chk("lat7 rdata_held", 32'(bus[2].rdata), 32'hB5);

    for (int g = 0; g < 3; g++) chk($sformatf("dut%0d pending_done", g), sb[g].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
